rr_arb_4: RTL and testbench

RR_ARB_4 -- requirements
Module: rr_arb_4

---
 rtl/rr_arb_4.sv | 91 +++++++++
 tb/tb_rr_arb_4.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4.sv
// rtl/rr_arb_4.sv - 4-way round-robin arbiter with hold limit and registered 4:1 data select
module rr_arb_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [1:0] ptr;
    logic [7:0] cnt;

    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [3:0] mask;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       do_grant;
    logic       drop;

    assign owner_oh = 4'b0001 << sel;
    assign others   = req & ~owner_oh;

    // While the owner still requests, only a preemption can move the grant, so it is excluded.
    assign mask = (state == S_GRANT && req[sel]) ? others : req;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        do_grant = 1'b0;
        drop     = 1'b0;
        if (state == S_IDLE) begin
            do_grant = |req;
        end else if (!req[sel]) begin
            do_grant = |req;
            drop     = ~|req;
        end else if (cnt == HOLD_LAST && |others) begin
            do_grant = 1'b1;
        end
    end

    assign busy = state[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            out   <= 1'b0;
        end else begin
            out <= (state == S_GRANT) ? a[sel] : 1'b0;
            if (do_grant) begin
                state <= S_GRANT;
                sel   <= pick;
                gnt   <= 4'b0001 << pick;
                ptr   <= pick + 2'd1;
                cnt   <= 8'd0;
            end else if (drop) begin
                state <= S_IDLE;
                gnt   <= 4'b0000;
            end else if (state == S_GRANT && cnt != HOLD_LAST) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_4.sv
// tb/tb_rr_arb_4.sv - directed bench for rr_arb_4 with a cycle-level reference model
module tb_rr_arb_4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out;

    int n_cmp = 0;
    int n_bad = 0;

    rr_arb_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a),
        .gnt(gnt), .sel(sel), .busy(busy), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index, pointer, hold count tracked as plain integers.
    int m_busy, m_sel, m_ptr, m_cnt, m_out;

    function automatic int rr_pick(input int start, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        logic [3:0] rest;
        if (!rst_n) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_out = 0;
        end else begin
            m_out = m_busy ? int'(a[m_sel]) : 0;
            rest  = req & ~(4'b0001 << m_sel);
            w     = -1;
            if (m_busy == 0 || !req[m_sel]) begin
                w = rr_pick(m_ptr, req);
                if (w < 0) m_busy = 0;
            end else if (m_cnt == MAX_HOLD - 1 && rest != 0) begin
                w = rr_pick(m_ptr, rest);
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_gnt", int'(gnt), m_busy ? (1 << m_sel) : 0);
        chk("model_sel", int'(sel), m_sel);
        chk("model_busy", int'(busy), m_busy);
        chk("model_out", int'(out), m_out);
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] d);
        @(negedge clk);
        req = r;
        a   = d;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit glitch;
        rst_n = 1'b0;
        req   = 4'b0000;
        a     = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out", int'(out), 0);
        rst_n = 1'b1;

        drive(4'b0100, 4'b0100);
        edge1();
        chk("r026_gnt", int'(gnt), 4);
        chk("r026_sel", int'(sel), 2);
        chk("r026_busy", int'(busy), 1);
        chk("r026_out_lag", int'(out), 0);
        edge1();
        chk("r026_out", int'(out), 1);

        drive(4'b0000, 4'b0000);
        edge1();
        chk("idle_busy", int'(busy), 0);
        chk("idle_sel_hold", int'(sel), 2);

        drive(4'b0101, 4'b0000);
        edge1();
        chk("r029_wrap", int'(gnt), 1);

        drive(4'b0010, 4'b0000);
        edge1();
        chk("handoff_1", int'(gnt), 2);
        drive(4'b1010, 4'b0000);
        edge1();
        drive(4'b1000, 4'b0000);
        edge1();
        chk("r028_gnt", int'(gnt), 8);
        chk("r028_busy", int'(busy), 1);
        drive(4'b0000, 4'b0000);
        edge1();
        chk("r028_drop_gnt", int'(gnt), 0);
        chk("r028_drop_busy", int'(busy), 0);

        drive(4'b1111, 4'b0101);
        for (int i = 0; i < 40; i++) begin
            edge1();
            chk("r027_rotate", int'(gnt), 1 << ((i / 8) % 4));
            chk("r027_busy", int'(busy), 1);
        end

        drive(4'b0001, 4'b0001);
        glitch = 1'b0;
        for (int i = 0; i < 300; i++) begin
            edge1();
            if (gnt != 4'b0001 || busy != 1'b1) glitch = 1'b1;
        end
        chk("r030_no_glitch", int'(glitch), 0);
        chk("r030_cnt_sat", int'(dut.cnt), 7);

        drive(4'b1000, 4'b1000);
        edge1();
        chk("pre031_gnt", int'(gnt), 8);
        edge1();
        chk("pre031_out", int'(out), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("r031_gnt", int'(gnt), 0);
        chk("r031_sel", int'(sel), 0);
        chk("r031_busy", int'(busy), 0);
        chk("r031_out", int'(out), 0);
        #1 rst_n = 1'b1;
        edge1();
        chk("r031_regrant_gnt", int'(gnt), 8);
        chk("r031_regrant_sel", int'(sel), 3);
        chk("r031_out_lag", int'(out), 0);
        edge1();
        chk("r031_out", int'(out), 1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
